// File: rtl/dram_bus_bridge_if.sv
// Core-side memory port of the DRAM bus bridge.
//   io_ren/io_raddr      : read request, held until io_rvalid
//   io_rdata/io_rvalid   : read completion (one-cycle pulse)
//   io_wen/io_waddr/io_wdata/io_wstrb : write request, held until io_wready
//   io_wready            : write completion (one-cycle pulse)
// master = the core issuing requests, slave = the bridge serving them.
interface dram_bus_bridge_if;
  logic        io_ren;
  logic [31:0] io_raddr;
  logic [31:0] io_rdata;
  logic        io_rvalid;
  logic        io_wen;
  logic [31:0] io_waddr;
  logic [31:0] io_wdata;
  logic [3:0]  io_wstrb;
  logic        io_wready;

  modport master (
    output io_ren, io_raddr, io_wen, io_waddr, io_wdata, io_wstrb,
    input  io_rdata, io_rvalid, io_wready
  );

  modport slave (
    input  io_ren, io_raddr, io_wen, io_waddr, io_wdata, io_wstrb,
    output io_rdata, io_rvalid, io_wready
  );
endinterface

// File: rtl/dram_bus_bridge.sv
// DRAM bus bridge: turns 32-bit single-word core reads/writes into 128-bit
// line commands on the DRAM wrapper user interface, with a one-line read
// buffer so repeated reads of the same line skip the DRAM.
// Ports:
//   clock, reset                 : user clock, synchronous active-high reset
//   core                         : core memory port (slave side of the interface)
//   io_dram_ren / io_dram_wen    : one-cycle DRAM command pulses
//   io_dram_addr                 : line address {byte_addr[27:4], 3'b000}
//   io_dram_wdata / io_dram_wmask: replicated write word, byte mask (1 = keep)
//   io_dram_user_busy            : tied 0, read data is always accepted
//   io_dram_init_calib_complete  : commands held off until calibration is done
//   io_dram_rdata(_valid)        : returned read line
//   io_dram_busy                 : DRAM cannot take a command this cycle
module dram_bus_bridge #(
  parameter int APP_ADDR_WIDTH  = 28,
  parameter int APP_DATA_WIDTH  = 128,
  parameter int APP_MASK_WIDTH  = 16,
  parameter bit ENABLE_LINE_BUF = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  dram_bus_bridge_if.slave            core,
  output logic                        io_dram_ren,
  output logic                        io_dram_wen,
  output logic [APP_ADDR_WIDTH-2:0]   io_dram_addr,
  output logic [APP_DATA_WIDTH-1:0]   io_dram_wdata,
  output logic [APP_MASK_WIDTH-1:0]   io_dram_wmask,
  output logic                        io_dram_user_busy,
  input  logic                        io_dram_init_calib_complete,
  input  logic [APP_DATA_WIDTH-1:0]   io_dram_rdata,
  input  logic                        io_dram_rdata_valid,
  input  logic                        io_dram_busy
);

  localparam int TAG_W = APP_ADDR_WIDTH - 4;

  typedef enum logic [2:0] {
    IDLE,
    W_ISSUE,
    W_RESP,
    R_ISSUE,
    R_WAIT,
    R_RESP
  } state_t;

  // Byte mask for one 32-bit word placed in its lane; 1 = byte not written.
  function automatic logic [APP_MASK_WIDTH-1:0] make_wmask(
    input logic [3:0] strb,
    input logic [1:0] lane
  );
    logic [APP_MASK_WIDTH-1:0] m;
    m = {{(APP_MASK_WIDTH-4){1'b0}}, strb} << {lane, 2'b00};
    return ~m;
  endfunction

  function automatic logic [31:0] lane_word(
    input logic [APP_DATA_WIDTH-1:0] line,
    input logic [1:0]                lane
  );
    return line[{lane, 5'b00000} +: 32];
  endfunction

  // Overlay the unmasked bytes of new_line onto line (write-through update).
  function automatic logic [APP_DATA_WIDTH-1:0] merge_bytes(
    input logic [APP_DATA_WIDTH-1:0] line,
    input logic [APP_DATA_WIDTH-1:0] new_line,
    input logic [APP_MASK_WIDTH-1:0] mask
  );
    logic [APP_DATA_WIDTH-1:0] r;
    r = line;
    for (int i = 0; i < APP_MASK_WIDTH; i++) begin
      if (!mask[i]) r[8*i +: 8] = new_line[8*i +: 8];
    end
    return r;
  endfunction

  state_t                    state;
  logic                      buf_valid;
  logic [TAG_W-1:0]          buf_tag;
  logic [APP_DATA_WIDTH-1:0] buf_line;
  logic [1:0]                lane_q;

  logic                      dram_ren_q;
  logic                      dram_wen_q;
  logic [APP_ADDR_WIDTH-2:0] dram_addr_q;
  logic [APP_DATA_WIDTH-1:0] dram_wdata_q;
  logic [APP_MASK_WIDTH-1:0] dram_wmask_q;
  logic                      rvalid_q;
  logic [31:0]               rdata_q;
  logic                      wready_q;

  logic [TAG_W-1:0]          rd_tag;
  logic [TAG_W-1:0]          wr_tag;
  logic [1:0]                rd_lane;
  logic [1:0]                wr_lane;
  logic                      cmd_ok;
  logic                      rd_hit;
  logic                      wr_hit;
  logic [APP_MASK_WIDTH-1:0] wr_mask;
  logic [APP_DATA_WIDTH-1:0] wr_line;
  logic                      unused_addr_bits;

  // Bits above the DRAM window wrap; bits [1:0] are ignored for word access.
  assign rd_tag  = core.io_raddr[APP_ADDR_WIDTH-1:4];
  assign wr_tag  = core.io_waddr[APP_ADDR_WIDTH-1:4];
  assign rd_lane = core.io_raddr[3:2];
  assign wr_lane = core.io_waddr[3:2];
  assign unused_addr_bits = ^{core.io_raddr[31:APP_ADDR_WIDTH], core.io_raddr[1:0],
                              core.io_waddr[31:APP_ADDR_WIDTH], core.io_waddr[1:0]};

  assign cmd_ok  = io_dram_init_calib_complete && !io_dram_busy;
  assign rd_hit  = ENABLE_LINE_BUF && buf_valid && (buf_tag == rd_tag);
  assign wr_hit  = buf_valid && (buf_tag == wr_tag);
  assign wr_mask = make_wmask(core.io_wstrb, wr_lane);
  assign wr_line = {(APP_DATA_WIDTH/32){core.io_wdata}};

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      buf_valid    <= 1'b0;
      dram_ren_q   <= 1'b0;
      dram_wen_q   <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      dram_wmask_q <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      wready_q     <= 1'b0;
    end else begin
      dram_ren_q <= 1'b0;
      dram_wen_q <= 1'b0;
      rvalid_q   <= 1'b0;
      wready_q   <= 1'b0;
      case (state)
        IDLE: begin
          // Writes win a collision; the held read is served right after.
          if (core.io_wen) begin
            state <= W_ISSUE;
          end else if (core.io_ren) begin
            lane_q <= rd_lane;
            state  <= rd_hit ? R_RESP : R_ISSUE;
          end
        end
        W_ISSUE: begin
          if (cmd_ok) begin
            dram_wen_q   <= 1'b1;
            dram_addr_q  <= {wr_tag, 3'b000};
            dram_wdata_q <= wr_line;
            dram_wmask_q <= wr_mask;
            // Keep the buffered line coherent with what DRAM now holds.
            if (wr_hit) buf_line <= merge_bytes(buf_line, wr_line, wr_mask);
            state <= W_RESP;
          end
        end
        W_RESP: begin
          wready_q <= 1'b1;
          state    <= IDLE;
        end
        R_ISSUE: begin
          if (cmd_ok) begin
            dram_ren_q  <= 1'b1;
            dram_addr_q <= {rd_tag, 3'b000};
            buf_tag     <= rd_tag;
            buf_valid   <= 1'b0;
            state       <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (io_dram_rdata_valid) begin
            buf_line  <= io_dram_rdata;
            buf_valid <= 1'b1;
            state     <= R_RESP;
          end
        end
        R_RESP: begin
          rvalid_q <= 1'b1;
          rdata_q  <= lane_word(buf_line, lane_q);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_dram_ren       = dram_ren_q;
  assign io_dram_wen       = dram_wen_q;
  assign io_dram_addr      = dram_addr_q;
  assign io_dram_wdata     = dram_wdata_q;
  assign io_dram_wmask     = dram_wmask_q;
  assign io_dram_user_busy = 1'b0;
  assign core.io_rvalid    = rvalid_q;
  assign core.io_rdata     = rdata_q;
  assign core.io_wready    = wready_q;

endmodule

// File: tb/tb_dram_bus_bridge.sv
module tb_dram_bus_bridge;

  logic         clock;
  logic         reset;
  logic         dren, dwen, user_busy;
  logic [26:0]  daddr;
  logic [127:0] dwdata;
  logic [15:0]  dwmask;
  logic         calib;
  logic [127:0] drdata;
  logic         drv;
  logic         dbusy;

  int errors = 0;
  int checks = 0;
  bit both_seen = 0;

  dram_bus_bridge_if bus();

  dram_bus_bridge dut (
    .clock                       (clock),
    .reset                       (reset),
    .core                        (bus),
    .io_dram_ren                 (dren),
    .io_dram_wen                 (dwen),
    .io_dram_addr                (daddr),
    .io_dram_wdata               (dwdata),
    .io_dram_wmask               (dwmask),
    .io_dram_user_busy           (user_busy),
    .io_dram_init_calib_complete (calib),
    .io_dram_rdata               (drdata),
    .io_dram_rdata_valid         (drv),
    .io_dram_busy                (dbusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
    if (dren && dwen) both_seen = 1;
  endtask

  // Read with a DRAM model that answers 2 cycles after each io_dram_ren.
  task automatic do_read(input logic [31:0] a, input logic [127:0] line,
                         output logic [31:0] d, output int nren, output int lat);
    int cd;
    bit got;
    cd = -1; got = 0; nren = 0; lat = -1; d = 'x;
    bus.io_raddr = a;
    bus.io_ren   = 1'b1;
    for (int c = 1; c <= 200 && !got; c++) begin
      tick();
      drv = 1'b0;
      if (dren) begin
        nren++;
        cd = 2;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          drdata = line;
          drv    = 1'b1;
          cd     = -1;
        end
      end
      if (bus.io_rvalid) begin
        got = 1;
        d   = bus.io_rdata;
        lat = c;
      end
    end
    bus.io_ren = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                          output logic [26:0] ca, output logic [127:0] cd, output logic [15:0] cm,
                          output int nwen, output int wen_cyc, output int rdy_cyc);
    bit got;
    got = 0; nwen = 0; wen_cyc = -10; rdy_cyc = -1;
    ca = 'x; cd = 'x; cm = 'x;
    bus.io_waddr = a;
    bus.io_wdata = wd;
    bus.io_wstrb = st;
    bus.io_wen   = 1'b1;
    for (int c = 1; c <= 200 && !got; c++) begin
      tick();
      if (dwen) begin
        nwen++;
        wen_cyc = c;
        ca = daddr; cd = dwdata; cm = dwmask;
      end
      if (bus.io_wready) begin
        got = 1;
        rdy_cyc = c;
      end
    end
    bus.io_wen = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({dren, dwen, daddr, dwdata, dwmask, user_busy, bus.io_rvalid, bus.io_rdata, bus.io_wready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ren=%b wen=%b addr=%h wmask=%h rvalid=%b wready=%b required all zero",
               dren, dwen, daddr, dwmask, bus.io_rvalid, bus.io_wready);
    end
    reset = 1'b0;
  endtask

  task automatic test_write_readback();
    logic [26:0] ca; logic [127:0] cdat; logic [15:0] cm;
    int nw, wc, rc, nren, lat;
    logic [31:0] d;
    calib = 1'b1;
    do_write(32'h0000_0014, 32'hDEADBEEF, 4'hF, ca, cdat, cm, nw, wc, rc);
    checks++;
    if (ca !== 27'h0000008) begin errors++; $display("FAIL wr_addr: got %h required %h", ca, 27'h0000008); end
    checks++;
    if (cm !== 16'hFF0F) begin errors++; $display("FAIL wr_mask: got %h required %h", cm, 16'hFF0F); end
    checks++;
    if (cdat !== {4{32'hDEADBEEF}}) begin errors++; $display("FAIL wr_data: got %h required %h", cdat, {4{32'hDEADBEEF}}); end
    checks++;
    if (nw !== 1 || rc !== wc + 1) begin
      errors++; $display("FAIL wr_ready_timing: wen pulses %0d at %0d, wready at %0d, required 1 pulse and wready one cycle later", nw, wc, rc);
    end
    do_read(32'h0000_0014, {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11111111}, d, nren, lat);
    checks++;
    if (d !== 32'hDEADBEEF || nren !== 1) begin
      errors++; $display("FAIL readback: got %h with %0d dram reads, required deadbeef with 1", d, nren);
    end
  endtask

  task automatic test_buffer_hit();
    int nren, lat;
    logic [31:0] d;
    do_read(32'h0000_0020, {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0}, d, nren, lat);
    checks++;
    if (d !== 32'hA0A0A0A0 || nren !== 1) begin
      errors++; $display("FAIL miss_read: got %h with %0d dram reads, required a0a0a0a0 with 1", d, nren);
    end
    do_read(32'h0000_002C, '0, d, nren, lat);
    checks++;
    if (d !== 32'hA3A3A3A3 || nren !== 0) begin
      errors++; $display("FAIL hit_read: got %h with %0d dram reads, required a3a3a3a3 with 0", d, nren);
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL hit_latency: got %0d required 2", lat); end
  endtask

  task automatic test_partial_write();
    logic [26:0] ca; logic [127:0] cdat; logic [15:0] cm;
    int nw, wc, rc, nren, lat;
    logic [31:0] d;
    do_read(32'h0000_0030, {32'h99AABBCC, 32'hDDEEFF00, 32'h55667788, 32'h10203040}, d, nren, lat);
    checks++;
    if (d !== 32'h10203040) begin errors++; $display("FAIL pw_fill: got %h required %h", d, 32'h10203040); end
    do_write(32'h0000_0034, 32'h0000ABCD, 4'b0011, ca, cdat, cm, nw, wc, rc);
    checks++;
    if (cm !== 16'hFFCF || ca !== 27'h0000018) begin
      errors++; $display("FAIL pw_cmd: mask %h addr %h, required ffcf and 0000018", cm, ca);
    end
    do_read(32'h0000_0034, '0, d, nren, lat);
    checks++;
    if (d !== 32'h5566ABCD || nren !== 0) begin
      errors++; $display("FAIL pw_merge: got %h with %0d dram reads, required 5566abcd with 0", d, nren);
    end
    do_read(32'h0000_0038, '0, d, nren, lat);
    checks++;
    if (d !== 32'hDDEEFF00 || nren !== 0) begin
      errors++; $display("FAIL pw_other_lane: got %h with %0d dram reads, required ddeeff00 with 0", d, nren);
    end
  endtask

  task automatic test_collision();
    int nw, nr, first, wcyc, rcyc, cd;
    bit rgot;
    logic [26:0] wa;
    logic [31:0] d;
    nw = 0; nr = 0; first = 0; wcyc = 1000; rcyc = -1; cd = -1; rgot = 0; wa = 'x; d = 'x;
    bus.io_waddr = 32'h0000_0050; bus.io_wdata = 32'h12345678; bus.io_wstrb = 4'hF;
    bus.io_raddr = 32'h0000_0060;
    bus.io_wen = 1'b1; bus.io_ren = 1'b1;
    for (int c = 1; c <= 300 && !rgot; c++) begin
      tick();
      drv = 1'b0;
      if (dwen) begin nw++; wa = daddr; if (first == 0) first = 1; end
      if (dren) begin
        nr++; cd = 2; if (first == 0) first = 2;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin drdata = {96'h0, 32'hCAFEF00D}; drv = 1'b1; cd = -1; end
      end
      if (bus.io_wready) begin wcyc = c; bus.io_wen = 1'b0; end
      if (bus.io_rvalid) begin rcyc = c; d = bus.io_rdata; rgot = 1; end
    end
    bus.io_wen = 1'b0; bus.io_ren = 1'b0;
    checks++;
    if (first !== 1 || nw !== 1 || nr !== 1) begin
      errors++; $display("FAIL coll_order: first cmd %0d, writes %0d, reads %0d, required write first, 1 and 1", first, nw, nr);
    end
    checks++;
    if (!(wcyc < rcyc) || d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL coll_complete: wready at %0d rvalid at %0d data %h, required write before read and cafef00d", wcyc, rcyc, d);
    end
    checks++;
    if (wa !== 27'h0000028) begin errors++; $display("FAIL coll_waddr: got %h required %h", wa, 27'h0000028); end
  endtask

  task automatic test_spurious();
    int rv, nren, lat;
    logic [31:0] d;
    rv = 0;
    drdata = {128{1'b1}};
    drv = 1'b1;
    tick();
    drv = 1'b0;
    if (bus.io_rvalid) rv++;
    repeat (5) begin tick(); if (bus.io_rvalid) rv++; end
    checks++;
    if (rv !== 0) begin errors++; $display("FAIL stray_rvalid: got %0d pulses required 0", rv); end
    do_read(32'h0000_0060, '0, d, nren, lat);
    checks++;
    if (d !== 32'hCAFEF00D || nren !== 0) begin
      errors++; $display("FAIL stray_buffer: got %h with %0d dram reads, required cafef00d with 0", d, nren);
    end
  endtask

  task automatic test_gating();
    int early, nren, cd;
    bit got;
    logic [31:0] d;
    early = 0; nren = 0; cd = -1; got = 0; d = 'x;
    calib = 1'b0; dbusy = 1'b0;
    bus.io_raddr = 32'h0000_0074;
    bus.io_ren = 1'b1;
    for (int c = 1; c <= 300 && !got; c++) begin
      tick();
      drv = 1'b0;
      calib = (c >= 50);
      dbusy = (c >= 50 && c < 55);
      if (dren) begin
        nren++; cd = 2;
        if (c <= 55) early++;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin drdata = {64'h0, 32'h0BADC0DE, 32'h0}; drv = 1'b1; cd = -1; end
      end
      if (bus.io_rvalid) begin got = 1; d = bus.io_rdata; end
    end
    bus.io_ren = 1'b0;
    checks++;
    if (early !== 0 || nren !== 1) begin
      errors++; $display("FAIL gating: %0d early and %0d total dram reads, required 0 and 1", early, nren);
    end
    checks++;
    if (d !== 32'h0BADC0DE) begin errors++; $display("FAIL gating_data: got %h required %h", d, 32'h0BADC0DE); end
  endtask

  task automatic test_reset_rwait();
    bit seen;
    int rv, nren, lat;
    logic [31:0] d;
    seen = 0; rv = 0;
    bus.io_raddr = 32'h0000_0080;
    bus.io_ren = 1'b1;
    for (int c = 1; c <= 50 && !seen; c++) begin
      tick();
      if (dren) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL rst_issue: got no dram read required one"); end
    reset = 1'b1;
    bus.io_ren = 1'b0;
    tick(); tick();
    checks++;
    if ({dren, dwen, daddr, dwdata, dwmask, bus.io_rvalid, bus.io_rdata, bus.io_wready} !== '0) begin
      errors++; $display("FAIL rst_midway_outputs: addr=%h rdata=%h required all zero", daddr, bus.io_rdata);
    end
    reset = 1'b0;
    drdata = {4{32'hBAADBAAD}};
    drv = 1'b1;
    tick();
    drv = 1'b0;
    if (bus.io_rvalid) rv++;
    repeat (4) begin tick(); if (bus.io_rvalid) rv++; end
    checks++;
    if (rv !== 0) begin errors++; $display("FAIL rst_late_data: got %0d rvalid pulses required 0", rv); end
    do_read(32'h0000_0080, {96'h0, 32'h600DF00D}, d, nren, lat);
    checks++;
    if (d !== 32'h600DF00D || nren !== 1) begin
      errors++; $display("FAIL rst_reread: got %h with %0d dram reads, required 600df00d with 1", d, nren);
    end
  endtask

  initial begin
    reset = 1'b1;
    calib = 1'b0;
    dbusy = 1'b0;
    drv = 1'b0;
    drdata = '0;
    bus.io_ren = 1'b0; bus.io_raddr = '0;
    bus.io_wen = 1'b0; bus.io_waddr = '0; bus.io_wdata = '0; bus.io_wstrb = '0;
    test_reset();
    test_write_readback();
    test_buffer_hit();
    test_partial_write();
    test_collision();
    test_spurious();
    test_gating();
    test_reset_rwait();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL cmd_exclusive: got ren and wen together required never"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
